// File: rtl/ps2_tx_fifo_mc.sv
// rtl/ps2_tx_fifo_mc.sv - multi-channel PS/2 device-side transmitter with per-channel byte FIFO
module ps2_tx_fifo_mc #(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100,
    parameter int GAP_HALF  = 4
) (
    input  logic                              clk_sys,
    input  logic                              reset_n,
    input  logic [CHANNELS-1:0]               wr_en,
    input  logic [8*CHANNELS-1:0]             wr_data,
    input  logic [CHANNELS-1:0]               flush,
    input  logic [CHANNELS-1:0]               ovf_clr,
    input  logic [CHANNELS-1:0]               host_clk_in,
    output logic [CHANNELS-1:0]               ps2_clk,
    output logic [CHANNELS-1:0]               ps2_data,
    output logic [CHANNELS-1:0]               busy,
    output logic [CHANNELS-1:0]               fifo_full,
    output logic [(FIFO_BITS+1)*CHANNELS-1:0] fifo_level,
    output logic [CHANNELS-1:0]               overflow
);
    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int LVL_W = FIFO_BITS + 1;
    localparam int DIV_W = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(PS2DIV - 1);
    localparam logic [7:0]       GAP_LAST = 8'(GAP_HALF - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

    logic [DIV_W-1:0] div_cnt;
    logic             ph;
    logic             tick;
    logic             rise;
    logic             fall;

    assign tick = (div_cnt == DIV_LAST);
    assign rise = tick & ~ph;
    assign fall = tick & ph;

    // Shared half-period timebase: tick every PS2DIV cycles, ph selects RISE/FALL
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            div_cnt <= '0;
            ph      <= 1'b0;
        end else if (tick) begin
            div_cnt <= '0;
            ph      <= ~ph;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [7:0]           mem [DEPTH];
        logic [FIFO_BITS-1:0] wr_ptr;
        logic [FIFO_BITS-1:0] rd_ptr;
        logic [LVL_W-1:0]     level;
        logic                 ovf;
        state_t               state;
        logic                 clk_q;
        logic                 dat_q;
        logic [3:0]           idx;
        logic [7:0]           shreg;
        logic                 par;
        logic [7:0]           gap_cnt;
        logic                 sync1;
        logic                 hs;
        logic [1:0]           hi_cnt;
        logic                 inhibit;
        logic                 full;
        logic                 empty;
        logic                 commit;
        logic                 push_ok;
        logic                 drop;
        logic [7:0]           din;

        assign din     = wr_data[8*c +: 8];
        assign full    = (level == LVL_FULL);
        assign empty   = (level == '0);
        // The host can only be seen pulling low once our own clock has been released a while
        assign inhibit = ~hs & (hi_cnt == 2'd3);
        assign commit  = (state == S_SEND) & rise & (idx == 4'd10) & ~inhibit;
        // A commit frees a slot in the same cycle, so a push into a full FIFO still lands
        assign push_ok = wr_en[c] & ~flush[c] & (~full | commit);
        assign drop    = wr_en[c] & ~flush[c] & full & ~commit;

        // Host clock synchroniser and run length of our own released clock
        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                sync1  <= 1'b1;
                hs     <= 1'b1;
                hi_cnt <= 2'd0;
            end else begin
                sync1 <= host_clk_in[c];
                hs    <= sync1;
                if (!clk_q) begin
                    hi_cnt <= 2'd0;
                end else if (hi_cnt != 2'd3) begin
                    hi_cnt <= hi_cnt + 2'd1;
                end
            end
        end

        // FIFO storage write port
        always_ff @(posedge clk_sys) begin
            if (reset_n && push_ok) begin
                mem[wr_ptr] <= din;
            end
        end

        // FIFO pointers, level and sticky overflow
        always_ff @(posedge clk_sys) begin
            if (!reset_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                ovf    <= 1'b0;
            end else if (flush[c]) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                level  <= '0;
                if (ovf_clr[c]) begin
                    ovf <= 1'b0;
                end
            end else begin
                if (push_ok) begin
                    wr_ptr <= wr_ptr + FIFO_BITS'(1);
                end
                if (commit) begin
                    rd_ptr <= rd_ptr + FIFO_BITS'(1);
                end
                if (push_ok && !commit) begin
                    level <= level + LVL_W'(1);
                end else if (!push_ok && commit) begin
                    level <= level - LVL_W'(1);
                end
                if (drop) begin
                    ovf <= 1'b1;
                end else if (ovf_clr[c]) begin
                    ovf <= 1'b0;
                end
            end
        end

        // Frame serialiser: IDLE -> SEND -> GAP -> IDLE, lines are registered
        always_ff @(posedge clk_sys) begin
            if (!reset_n || flush[c]) begin
                state   <= S_IDLE;
                clk_q   <= 1'b1;
                dat_q   <= 1'b1;
                idx     <= 4'd0;
                shreg   <= 8'd0;
                par     <= 1'b0;
                gap_cnt <= 8'd0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (rise && !empty && !inhibit) begin
                            shreg <= mem[rd_ptr];
                            par   <= 1'b1;
                            dat_q <= 1'b0;
                            idx   <= 4'd0;
                            state <= S_SEND;
                        end
                    end
                    S_SEND: begin
                        if (inhibit) begin
                            // Abandon the frame; the byte stays queued and is resent whole
                            clk_q <= 1'b1;
                            dat_q <= 1'b1;
                            state <= S_IDLE;
                        end else if (fall) begin
                            clk_q <= 1'b0;
                        end else if (rise) begin
                            clk_q <= 1'b1;
                            if (idx == 4'd10) begin
                                dat_q   <= 1'b1;
                                gap_cnt <= 8'd0;
                                state   <= S_GAP;
                            end else begin
                                idx <= idx + 4'd1;
                                if (idx < 4'd8) begin
                                    dat_q <= shreg[0];
                                    par   <= par ^ shreg[0];
                                    shreg <= {1'b0, shreg[7:1]};
                                end else if (idx == 4'd8) begin
                                    dat_q <= par;
                                end else begin
                                    dat_q <= 1'b1;
                                end
                            end
                        end
                    end
                    S_GAP: begin
                        clk_q <= 1'b1;
                        dat_q <= 1'b1;
                        if (tick) begin
                            if (gap_cnt == GAP_LAST) begin
                                state <= S_IDLE;
                            end else begin
                                gap_cnt <= gap_cnt + 8'd1;
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end

        assign ps2_clk[c]                     = clk_q;
        assign ps2_data[c]                    = dat_q;
        assign busy[c]                        = (state != S_IDLE);
        assign fifo_full[c]                   = full;
        assign fifo_level[LVL_W*c +: LVL_W]   = level;
        assign overflow[c]                    = ovf;
    end

endmodule

// File: tb/tb_ps2_tx_fifo_mc.sv
// tb/tb_ps2_tx_fifo_mc.sv - scoreboard bench for ps2_tx_fifo_mc
module tb_ps2_tx_fifo_mc;
    localparam int CH    = 2;
    localparam int FB    = 3;
    localparam int DIV   = 8;
    localparam int GAP   = 4;
    localparam int DEPTH = 8;
    localparam int LW    = FB + 1;
    localparam int LIMIT = 20000;

    logic            clk_sys = 1'b0;
    logic            reset_n = 1'b0;
    logic [CH-1:0]   wr_en = '0;
    logic [8*CH-1:0] wr_data = '0;
    logic [CH-1:0]   flush = '0;
    logic [CH-1:0]   ovf_clr = '0;
    logic [CH-1:0]   host_hold = '0;
    logic [CH-1:0]   host_clk_in;
    logic [CH-1:0]   ps2_clk;
    logic [CH-1:0]   ps2_data;
    logic [CH-1:0]   busy;
    logic [CH-1:0]   fifo_full;
    logic [LW*CH-1:0] fifo_level;
    logic [CH-1:0]   overflow;

    ps2_tx_fifo_mc #(.CHANNELS(CH), .FIFO_BITS(FB), .PS2DIV(DIV), .GAP_HALF(GAP)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .flush(flush), .ovf_clr(ovf_clr), .host_clk_in(host_clk_in),
        .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .fifo_full(fifo_full),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    // open-drain wired-AND of our clock drive with the host's pull-down
    assign host_clk_in = ps2_clk & ~host_hold;

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    logic [7:0]  q0[$];
    logic [7:0]  q1[$];
    bit          m_ovf [CH];
    int          nbits [CH];
    logic [10:0] fbits [CH];
    logic [10:0] last_bits [CH];
    int          run [CH];
    int          fall_cyc [CH];
    int          first_fall_cyc [CH];
    bit          after_commit [CH];

    function automatic int exp_size(int c);
        if (c == 0) return q0.size();
        return q1.size();
    endfunction

    function automatic void push_exp(int c, logic [7:0] b);
        if (c == 0) q0.push_back(b);
        else q1.push_back(b);
    endfunction

    function automatic logic [7:0] pop_exp(int c);
        if (c == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    function automatic void clear_exp(int c);
        if (c == 0) q0.delete();
        else q1.delete();
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Reference model and monitor: occupancy/overflow from the push rules, frames decoded off the lines
    always @(posedge clk_sys) begin
        logic [CH-1:0]   we;
        logic [CH-1:0]   fl;
        logic [CH-1:0]   oc;
        logic [CH-1:0]   clk_pre;
        logic [8*CH-1:0] wd;
        logic            rn;
        we = wr_en; fl = flush; oc = ovf_clr; wd = wr_data; rn = reset_n; clk_pre = ps2_clk;
        cyc++;
        #1;
        for (int c = 0; c < CH; c++) begin
            bit         dropped;
            logic [7:0] got;
            dropped = 1'b0;
            if (!rn) begin
                clear_exp(c);
                m_ovf[c] = 1'b0;
                nbits[c] = 0;
                run[c] = 0;
                after_commit[c] = 1'b0;
            end else if (fl[c]) begin
                clear_exp(c);
                nbits[c] = 0;
                run[c] = 0;
                after_commit[c] = 1'b0;
                if (oc[c]) m_ovf[c] = 1'b0;
            end else begin
                if (clk_pre[c] === 1'b1 && ps2_clk[c] === 1'b0) begin
                    if (nbits[c] == 0) begin
                        if (after_commit[c]) chk_range($sformatf("ch%0d_gap_idle", c), run[c], (GAP+1)*DIV, 1000000);
                        first_fall_cyc[c] = cyc;
                    end else begin
                        chk($sformatf("ch%0d_high_phase", c), run[c], DIV);
                    end
                    if (nbits[c] < 11) fbits[c][nbits[c]] = ps2_data[c];
                    nbits[c]++;
                    fall_cyc[c] = cyc;
                    run[c] = 1;
                end else if (clk_pre[c] === 1'b0 && ps2_clk[c] === 1'b1) begin
                    chk($sformatf("ch%0d_low_phase", c), run[c], DIV);
                    run[c] = 1;
                    if (nbits[c] == 11) begin
                        got = fbits[c][8:1];
                        chk($sformatf("ch%0d_start_bit", c), fbits[c][0], 0);
                        chk($sformatf("ch%0d_stop_bit", c), fbits[c][10], 1);
                        chk($sformatf("ch%0d_odd_parity", c), ^fbits[c][9:1], 1);
                        chk($sformatf("ch%0d_data_after_commit", c), ps2_data[c], 1);
                        if (exp_size(c) == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL ch%0d_frame_unexpected: got byte %02h expected no frame", c, got);
                        end else begin
                            chk($sformatf("ch%0d_frame_byte", c), got, pop_exp(c));
                        end
                        last_bits[c] = fbits[c];
                        nbits[c] = 0;
                        after_commit[c] = 1'b1;
                    end
                end else begin
                    run[c]++;
                    // a partial frame followed by a long released clock was abandoned by the device
                    if (ps2_clk[c] === 1'b1 && nbits[c] > 0 && run[c] > DIV + 2) begin
                        nbits[c] = 0;
                        after_commit[c] = 1'b0;
                    end
                end
                if (we[c]) begin
                    if (exp_size(c) < DEPTH) push_exp(c, wd[8*c +: 8]);
                    else begin
                        dropped = 1'b1;
                        m_ovf[c] = 1'b1;
                    end
                end
                if (oc[c] && !dropped) m_ovf[c] = 1'b0;
            end
            chk($sformatf("ch%0d_level", c), fifo_level[LW*c +: LW], exp_size(c));
            chk($sformatf("ch%0d_full", c), fifo_full[c], exp_size(c) == DEPTH);
            chk($sformatf("ch%0d_overflow", c), overflow[c], m_ovf[c]);
        end
    end

    task automatic push(input int c, input logic [7:0] b);
        @(negedge clk_sys);
        wr_en[c] = 1'b1;
        wr_data[8*c +: 8] = b;
        @(negedge clk_sys);
        wr_en[c] = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_size(0) != 0 || exp_size(1) != 0 || busy != '0) && n < LIMIT) begin
            @(negedge clk_sys);
            n++;
        end
        chk({name, "_drain_timeout"}, n < LIMIT, 1);
    endtask

    initial begin
        int n;
        int hold_left [CH];
        for (int c = 0; c < CH; c++) hold_left[c] = 0;

        repeat (3) @(negedge clk_sys);
        chk("rst_clk", ps2_clk, 2'b11);
        chk("rst_data", ps2_data, 2'b11);
        chk("rst_busy", busy, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_full", fifo_full, 0);
        chk("rst_ovf", overflow, 0);
        reset_n = 1'b1;
        repeat (5) @(negedge clk_sys);

        // single byte, start latency and exact bit pattern
        push(0, 8'hA5);
        n = 0;
        while (ps2_data[0] !== 1'b0 && n < 4*DIV) begin @(negedge clk_sys); n++; end
        chk_range("t1_start_latency", n, 1, 2*DIV);
        wait_drain("t1");
        chk("t1_bits", last_bits[0], {2'b11, 8'hA5, 1'b0});

        // overfill ch1 while the host inhibits it
        host_hold[1] = 1'b1;
        repeat (5) @(negedge clk_sys);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_sys);
            wr_en[1] = 1'b1;
            wr_data[15:8] = 8'(8'h40 + i);
        end
        @(negedge clk_sys);
        wr_en[1] = 1'b0;
        chk("t2_level", fifo_level[LW +: LW], 8);
        chk("t2_full", fifo_full[1], 1);
        chk("t2_overflow", overflow[1], 1);
        chk("t2_busy", busy[1], 0);
        ovf_clr[1] = 1'b1;
        @(negedge clk_sys);
        ovf_clr[1] = 1'b0;
        chk("t2_ovf_clr", overflow[1], 0);
        host_hold[1] = 1'b0;
        wait_drain("t2");

        // inhibit in the middle of a frame, then full resend
        push(0, 8'h3C);
        n = 0;
        while (!(nbits[0] == 4 && ps2_clk[0] === 1'b1) && n < LIMIT) begin @(negedge clk_sys); n++; end
        chk("t3_reach_bit4_timeout", n < LIMIT, 1);
        host_hold[0] = 1'b1;
        repeat (4) @(negedge clk_sys);
        chk("t3_clk_released", ps2_clk[0], 1);
        chk("t3_data_released", ps2_data[0], 1);
        chk("t3_busy", busy[0], 0);
        chk("t3_level_kept", fifo_level[LW-1:0], 1);
        repeat (296) @(negedge clk_sys);
        chk("t3_still_idle", busy[0], 0);
        host_hold[0] = 1'b0;
        wait_drain("t3");
        chk("t3_resent", last_bits[0][8:1], 8'h3C);

        // both channels loaded on the same edge start on the same RISE
        @(negedge clk_sys);
        wr_en = 2'b11;
        wr_data = {8'h08, 8'h12};
        @(negedge clk_sys);
        wr_en = 2'b01;
        wr_data[7:0] = 8'hF0;
        @(negedge clk_sys);
        wr_en = 2'b00;
        n = 0;
        while (!(nbits[0] >= 1 && nbits[1] >= 1) && n < LIMIT) begin @(negedge clk_sys); n++; end
        chk("t4_start_timeout", n < LIMIT, 1);
        chk("t4_same_rise", first_fall_cyc[0], first_fall_cyc[1]);
        wait_drain("t4");
        chk("t4_last_ch0", last_bits[0][8:1], 8'hF0);
        chk("t4_last_ch1", last_bits[1][8:1], 8'h08);

        // push into a full FIFO on the very edge that commits a frame
        for (int i = 0; i < 8; i++) begin
            @(negedge clk_sys);
            wr_en[0] = 1'b1;
            wr_data[7:0] = 8'(8'h80 + i);
        end
        @(negedge clk_sys);
        wr_en[0] = 1'b0;
        chk("t5_level8", fifo_level[LW-1:0], 8);
        n = 0;
        while (nbits[0] != 11 && n < LIMIT) begin @(negedge clk_sys); n++; end
        chk("t5_stop_timeout", n < LIMIT, 1);
        while (cyc != fall_cyc[0] + DIV - 1) @(negedge clk_sys);
        wr_en[0] = 1'b1;
        wr_data[7:0] = 8'hC9;
        @(negedge clk_sys);
        wr_en[0] = 1'b0;
        chk("t5_committed", nbits[0], 0);
        chk("t5_ovf", overflow[0], 0);
        chk("t5_level", fifo_level[LW-1:0], 8);
        wait_drain("t5");
        chk("t5_last", last_bits[0][8:1], 8'hC9);

        // flush mid-frame keeps overflow, reset mid-frame clears everything
        for (int i = 0; i < 9; i++) begin
            @(negedge clk_sys);
            wr_en[0] = 1'b1;
            wr_data[7:0] = 8'(8'h20 + i);
        end
        @(negedge clk_sys);
        wr_en[0] = 1'b0;
        n = 0;
        while (nbits[0] != 5 && n < LIMIT) begin @(negedge clk_sys); n++; end
        chk("t6_mid_timeout", n < LIMIT, 1);
        flush[0] = 1'b1;
        wr_en[0] = 1'b1;
        wr_data[7:0] = 8'h55;
        @(negedge clk_sys);
        flush[0] = 1'b0;
        wr_en[0] = 1'b0;
        chk("t6_flush_clk", ps2_clk[0], 1);
        chk("t6_flush_data", ps2_data[0], 1);
        chk("t6_flush_busy", busy[0], 0);
        chk("t6_flush_level", fifo_level[LW-1:0], 0);
        chk("t6_flush_ovf_kept", overflow[0], 1);
        push(0, 8'h66);
        n = 0;
        while (nbits[0] != 3 && n < LIMIT) begin @(negedge clk_sys); n++; end
        chk("t6_mid2_timeout", n < LIMIT, 1);
        reset_n = 1'b0;
        @(negedge clk_sys);
        reset_n = 1'b1;
        chk("t6_rst_clk", ps2_clk, 2'b11);
        chk("t6_rst_data", ps2_data, 2'b11);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_level", fifo_level, 0);
        chk("t6_rst_ovf", overflow, 0);
        repeat (3) @(negedge clk_sys);

        // randomized traffic with occasional host inhibits and overflow clears
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk_sys);
            for (int c = 0; c < CH; c++) begin
                wr_en[c] = ($urandom_range(0, 39) == 0);
                wr_data[8*c +: 8] = 8'($urandom);
                ovf_clr[c] = ($urandom_range(0, 299) == 0);
                if (hold_left[c] > 0) begin
                    hold_left[c]--;
                    if (hold_left[c] == 0) host_hold[c] = 1'b0;
                end else if ($urandom_range(0, 499) == 0) begin
                    hold_left[c] = $urandom_range(20, 80);
                    host_hold[c] = 1'b1;
                end
            end
        end
        @(negedge clk_sys);
        wr_en = '0;
        ovf_clr = '0;
        host_hold = '0;
        wait_drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
